parity_rr_sched: RTL and testbench

- Round-robin scheduler sharing one 4-bit parity generator among NUM_REQ nibble requesters.
- Each requester presents a 4-bit nibble with a valid/ready handshake.
- The block grants one requester per cycle, computes the parity bit, and registers nibble + parity + requester ID into a single output stage with valid/ready backpressure.
- Sits between nibble producers and the downstream parity-framed serial/packing logic.

---
 rtl/parity_rr_sched.sv | 145 ++++++++++++++
 tb/tb_parity_rr_sched.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/parity_rr_sched.sv
`default_nettype none
// ============================================================================
// Module   : parity_rr_sched
// Purpose  : Round-robin scheduler sharing one 4-bit parity generator among
//            NUM_REQ nibble requesters. The winning nibble, its even-ones
//            parity bit and the requester index are registered into a single
//            valid/ready output stage.
// Options  : PARITY_RR_SCHED_CNT_EN adds cnt_clr / out_cnt, a 16-bit
//            saturating count of completed output handshakes.
// Revision : 1.0 - initial release
// ============================================================================
module parity_rr_sched #(
  parameter  int NUM_REQ = 4,
  localparam int ID_W    = $clog2(NUM_REQ)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NUM_REQ-1:0]     req_valid,
  input  logic [4*NUM_REQ-1:0]   req_data,
  output logic [NUM_REQ-1:0]     req_ready,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [3:0]             out_data,
  output logic                   out_par,
  output logic [ID_W-1:0]        out_id
`ifdef PARITY_RR_SCHED_CNT_EN
  ,
  input  logic                   cnt_clr,
  output logic [15:0]            out_cnt
`endif
);

  localparam logic [0:0]    c_ST_EMPTY  = 1'b0;
  localparam logic [0:0]    c_ST_FULL   = 1'b1;
  localparam logic [ID_W:0] c_NUM_REQ_W = (ID_W+1)'(NUM_REQ);
  localparam logic [ID_W-1:0] c_LAST_ID = ID_W'(NUM_REQ - 1);

  logic [0:0]      r_state;
  logic [0:0]      w_state_nxt;
  logic [ID_W-1:0] r_ptr;
  logic [ID_W-1:0] w_gnt;
  logic            w_found;
  logic            w_load;
  logic            w_xfer;
  logic [3:0]      w_nib;
  logic [3:0]      r_data;
  logic            r_par;
  logic [ID_W-1:0] r_id;

  // Output register may take a new result when empty or being drained.
  assign w_load = ~out_valid | out_ready;

  // A transfer needs a winner, room in the output stage and reset released.
  assign w_xfer = rst_n & w_found & w_load;

  assign w_nib = req_data[4*w_gnt +: 4];

  // Round-robin search: first asserted request at or after r_ptr, with wrap.
  always_comb begin : p_arb
    logic [ID_W:0] v_idx;
    w_found = 1'b0;
    w_gnt   = '0;
    v_idx   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      v_idx = {1'b0, r_ptr} + (ID_W+1)'(k);
      if (v_idx >= c_NUM_REQ_W) begin
        v_idx = v_idx - c_NUM_REQ_W;
      end
      if (!w_found && req_valid[v_idx[ID_W-1:0]]) begin
        w_found = 1'b1;
        w_gnt   = v_idx[ID_W-1:0];
      end
    end
  end

  // One-hot accept towards the winner only when the transfer really happens.
  always_comb begin
    req_ready = '0;
    if (w_xfer) begin
      req_ready[w_gnt] = 1'b1;
    end
  end

  // State register: EMPTY / FULL tracks whether the output stage holds data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= c_ST_EMPTY;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state: fill on transfer, drain on out_ready without a refill.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_ST_EMPTY: if (w_xfer) w_state_nxt = c_ST_FULL;
      c_ST_FULL:  if (!w_xfer && out_ready) w_state_nxt = c_ST_EMPTY;
      default:    w_state_nxt = c_ST_EMPTY;
    endcase
  end

  // Output decode: the stage is valid exactly when FULL.
  always_comb begin
    out_valid = (r_state == c_ST_FULL);
  end

  // Result register and round-robin pointer advance on each transfer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_data <= 4'h0;
      r_par  <= 1'b0;
      r_id   <= '0;
      r_ptr  <= '0;
    end else if (w_xfer) begin
      r_data <= w_nib;
      r_par  <= ~^w_nib;
      r_id   <= w_gnt;
      r_ptr  <= (w_gnt == c_LAST_ID) ? '0 : w_gnt + 1'b1;
    end
  end

  assign out_data = r_data;
  assign out_par  = r_par;
  assign out_id   = r_id;

`ifdef PARITY_RR_SCHED_CNT_EN
  logic [15:0] r_cnt;

  // Saturating handshake counter; clear wins over increment.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= 16'h0000;
    end else if (cnt_clr) begin
      r_cnt <= 16'h0000;
    end else if (out_valid && out_ready && (r_cnt != 16'hFFFF)) begin
      r_cnt <= r_cnt + 16'h0001;
    end
  end

  assign out_cnt = r_cnt;
`endif

endmodule
`default_nettype wire

// File: tb/tb_parity_rr_sched.sv
`default_nettype none
// ============================================================================
// Module   : tb_parity_rr_sched
// Purpose  : Self-checking bench for parity_rr_sched. A transaction-level
//            model predicts grant, result register and (optionally) the
//            handshake counter; directed sequences pin literal values, then
//            randomized traffic runs against the model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_parity_rr_sched;

  localparam int NUM_REQ = 4;
  localparam int ID_W    = 2;

  logic                 clk       = 1'b0;
  logic                 rst_n     = 1'b1;
  logic [NUM_REQ-1:0]   req_valid = '0;
  logic [4*NUM_REQ-1:0] req_data  = '0;
  logic [NUM_REQ-1:0]   req_ready;
  logic                 out_valid;
  logic                 out_ready = 1'b0;
  logic [3:0]           out_data;
  logic                 out_par;
  logic [ID_W-1:0]      out_id;
`ifdef PARITY_RR_SCHED_CNT_EN
  logic                 cnt_clr   = 1'b0;
  logic [15:0]          out_cnt;
`endif

  int total = 0;
  int bad   = 0;

  parity_rr_sched #(.NUM_REQ(NUM_REQ)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_ready (req_ready),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_par   (out_par),
    .out_id    (out_id)
`ifdef PARITY_RR_SCHED_CNT_EN
    ,
    .cnt_clr   (cnt_clr),
    .out_cnt   (out_cnt)
`endif
  );

  always #5 clk = ~clk;

  // Reference model state: the output stage as a transaction record.
  logic        m_valid = 1'b0;
  logic [3:0]  m_data  = 4'h0;
  logic        m_par   = 1'b0;
  int          m_id    = 0;
  int          m_ptr   = 0;
  int          m_cnt   = 0;

  // Index the scheduler must serve this cycle, or -1 if nobody is accepted.
  function automatic int model_grant();
    if (!rst_n) return -1;
    if (m_valid && !out_ready) return -1;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (req_valid[(m_ptr + k) % NUM_REQ]) return (m_ptr + k) % NUM_REQ;
    end
    return -1;
  endfunction

  function automatic logic [NUM_REQ-1:0] model_ready();
    logic [NUM_REQ-1:0] r;
    int g;
    r = '0;
    g = model_grant();
    if (g >= 0) r[g] = 1'b1;
    return r;
  endfunction

  function automatic logic [3:0] nib_of(int g);
    return req_data[g*4 +: 4];
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Model update: one transaction step per clock, wiped by reset.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_valid <= 1'b0;
      m_data  <= 4'h0;
      m_par   <= 1'b0;
      m_id    <= 0;
      m_ptr   <= 0;
      m_cnt   <= 0;
    end else begin
      if (model_grant() >= 0) begin
        m_valid <= 1'b1;
        m_data  <= nib_of(model_grant());
        m_par   <= (($countones(nib_of(model_grant())) % 2) == 0);
        m_id    <= model_grant();
        m_ptr   <= (model_grant() + 1) % NUM_REQ;
      end else if (out_ready) begin
        m_valid <= 1'b0;
      end
`ifdef PARITY_RR_SCHED_CNT_EN
      if (cnt_clr) m_cnt <= 0;
      else if (m_valid && out_ready && m_cnt < 65535) m_cnt <= m_cnt + 1;
`endif
    end
  end

  // Compare DUT against the model every cycle, mid-way between edges.
  always @(negedge clk) begin
    check("req_ready", req_ready, model_ready());
    check("out_valid", out_valid, m_valid);
    if (m_valid) begin
      check("out_data", out_data, m_data);
      check("out_par", out_par, m_par);
      check("out_id", out_id, m_id);
    end
`ifdef PARITY_RR_SCHED_CNT_EN
    check("out_cnt", out_cnt, m_cnt);
`endif
  end

  logic [3:0] nibs [4];
  logic       pars [4];
  int         rr_ids [5];

  initial begin
    nibs   = '{4'h0, 4'h1, 4'hB, 4'hF};
    pars   = '{1'b1, 1'b0, 1'b0, 1'b1};
    rr_ids = '{0, 1, 2, 3, 0};

    // Reset with every requester asking.
    #1 rst_n = 1'b0;
    req_valid = 4'hF;
    req_data  = 16'h3210;
    repeat (2) @(posedge clk);
    #2;
    check("rst_req_ready", req_ready, 4'b0000);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_out_data", out_data, 4'h0);
    check("rst_out_par", out_par, 1'b0);
    check("rst_out_id", out_id, 0);

    // Release: requester 0 wins first, then strict rotation.
    out_ready = 1'b1;
    rst_n     = 1'b1;
    #1 check("first_grant", req_ready, 4'b0001);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("rr_id", out_id, rr_ids[i]);
      check("rr_data", out_data, rr_ids[i]);
      check("rr_ready_onehot", req_ready, 4'b0001 << ((rr_ids[i] + 1) % 4));
    end

    // Parity of a stream from requester 2.
    req_valid = 4'b0100;
    req_data  = 16'h0000;
    #1 check("par_ready", req_ready, 4'b0100);
    for (int i = 0; i < 4; i++) begin
      req_data = {4'h0, nibs[i], 8'h00};
      tick();
      check("par_valid", out_valid, 1'b1);
      check("par_bit", out_par, pars[i]);
      check("par_id", out_id, 2);
      check("par_data", out_data, nibs[i]);
    end
    req_valid = '0;
    tick();
    check("drain_valid", out_valid, 1'b0);

    // Skip and wrap, pointer now at 3.
    req_valid = 4'b0010;
    #1 check("skip_ready", req_ready, 4'b0010);
    tick();
    check("skip_id", out_id, 1);
    req_valid = 4'b0011;
    #1 check("wrap_ready", req_ready, 4'b0001);
    tick();
    check("wrap_id", out_id, 0);

    // Backpressure on a result of 4'hA.
    req_valid = 4'b0100;
    req_data  = 16'h5A00;
    tick();
    check("bp_data", out_data, 4'hA);
    out_ready = 1'b0;
    req_valid = 4'b1000;
    for (int i = 0; i < 3; i++) begin
      #1 check("bp_ready", req_ready, 4'b0000);
      tick();
      check("bp_hold_valid", out_valid, 1'b1);
      check("bp_hold_data", out_data, 4'hA);
      check("bp_hold_par", out_par, 1'b1);
      check("bp_hold_id", out_id, 2);
    end
    out_ready = 1'b1;
    #1 check("bp_release_ready", req_ready, 4'b1000);
    tick();
    check("bp_next_valid", out_valid, 1'b1);
    check("bp_next_data", out_data, 4'h5);
    check("bp_next_id", out_id, 3);
    req_valid = '0;
    tick();

    // Reset mid-stream, counter behaviour.
    rst_n = 1'b0;
    tick();
    rst_n     = 1'b1;
    req_valid = 4'hF;
    req_data  = 16'h3210;
    repeat (6) tick();
    check("mid_valid", out_valid, 1'b1);
`ifdef PARITY_RR_SCHED_CNT_EN
    check("cnt_five", out_cnt, 16'd5);
`endif
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", out_valid, 1'b0);
    check("mid_rst_ready", req_ready, 4'b0000);
`ifdef PARITY_RR_SCHED_CNT_EN
    check("mid_rst_cnt", out_cnt, 16'd0);
`endif
    tick();
    rst_n = 1'b1;
    #1 check("mid_rst_ptr", req_ready, 4'b0001);
    repeat (3) tick();
`ifdef PARITY_RR_SCHED_CNT_EN
    check("cnt_two", out_cnt, 16'd2);
    cnt_clr = 1'b1;
    tick();
    check("cnt_clr", out_cnt, 16'd0);
    cnt_clr = 1'b0;
`endif

    // Randomized traffic against the model.
    for (int n = 0; n < 3000; n++) begin
      tick();
      req_valid = 4'($urandom) & ((n % 3 == 0) ? 4'($urandom) : 4'hF);
      req_data  = 16'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      rst_n     = ($urandom_range(0, 299) != 0);
`ifdef PARITY_RR_SCHED_CNT_EN
      cnt_clr   = ($urandom_range(0, 49) == 0);
`endif
    end
    rst_n     = 1'b1;
    req_valid = '0;
    repeat (2) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
